// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencing FSM for a multicycle MIPS datapath.
// Latency: LW 5, SW 4, R-type/ADDI 4, BEQ/J 3 cycles, plus 1 per memory wait cycle.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold until mem_ready; all other states advance every cycle.
// Ports: clk/rst (sync, active-high); opcode, zero, mem_ready in; memory
// handshake, datapath enables and mux selects out; state, retired, trap for debug.
module multicycle_control #(
  parameter int         CNT_W     = 16,
  parameter logic [5:0] OPC_RTYPE = 6'h00,
  parameter logic [5:0] OPC_LW    = 6'h23,
  parameter logic [5:0] OPC_SW    = 6'h2B,
  parameter logic [5:0] OPC_BEQ   = 6'h04,
  parameter logic [5:0] OPC_J     = 6'h02,
  parameter logic [5:0] OPC_ADDI  = 6'h08
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             trap
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE   = 4'd6;
  localparam logic [3:0] S_ALU_WB    = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EX   = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;
  localparam logic [3:0] S_TRAP      = 4'd12;

  logic [3:0]       state_q, state_d;
  logic [5:0]       opc_q, opc_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  // State register, opcode latch and retired counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      opc_q     <= 6'h00;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic. The opcode is captured in DECODE so that MEM_ADDR
  // decides LW vs SW from the instruction actually decoded, even if the
  // live opcode input changes afterwards.
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        opc_d = opcode;
        if (opcode == OPC_LW || opcode == OPC_SW) state_d = S_MEM_ADDR;
        else if (opcode == OPC_RTYPE)             state_d = S_EXECUTE;
        else if (opcode == OPC_BEQ)               state_d = S_BRANCH;
        else if (opcode == OPC_J)                 state_d = S_JUMP;
        else if (opcode == OPC_ADDI)              state_d = S_ADDI_EX;
        else                                      state_d = S_TRAP;
      end
      S_MEM_ADDR:  state_d = (opc_q == OPC_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    begin state_d = S_FETCH; retire = 1'b1; end
      S_MEM_WRITE: if (mem_ready) begin state_d = S_FETCH; retire = 1'b1; end
      S_EXECUTE:   state_d = S_ALU_WB;
      S_ALU_WB:    begin state_d = S_FETCH; retire = 1'b1; end
      S_BRANCH:    begin state_d = S_FETCH; retire = 1'b1; end
      S_JUMP:      begin state_d = S_FETCH; retire = 1'b1; end
      S_ADDI_EX:   state_d = S_ADDI_WB;
      S_ADDI_WB:   begin state_d = S_FETCH; retire = 1'b1; end
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
    // Counter wraps naturally modulo 2^CNT_W.
    retired_d = retired_q + (retire ? CNT_W'(1) : CNT_W'(0));
  end

  // Moore outputs; only pc_write/ir_write look at zero/mem_ready as
  // qualifiers. Everything is forced low while rst is held.
  always_comb begin
    mem_req    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    trap       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_MEM_READ: begin mem_req = 1'b1; mem_read = 1'b1; i_or_d = 1'b1; end
      S_MEM_WB:   begin reg_write = 1'b1; mem_to_reg = 1'b1; end
      S_MEM_WRITE: begin mem_req = 1'b1; mem_write = 1'b1; i_or_d = 1'b1; end
      S_EXECUTE:  begin alu_src_a = 1'b1; alu_op = 2'b10; end
      S_ALU_WB:   begin reg_write = 1'b1; reg_dst = 1'b1; end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        pc_write  = zero;
      end
      S_JUMP:     begin pc_source = 2'b10; pc_write = 1'b1; end
      S_ADDI_EX:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_ADDI_WB:  reg_write = 1'b1;
      S_TRAP:     trap = 1'b1;
      default: ;
    endcase
    if (rst) begin
      mem_req    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_source  = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      trap       = 1'b0;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic        clk;
  logic        rst, rst2;
  logic [5:0]  opcode, opcode2;
  logic        zero, mem_ready, mem_ready2;

  logic        mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic        alu_src_a, reg_dst, reg_write, mem_to_reg, trap;
  logic [3:0]  state;
  logic [15:0] retired;

  logic        mem_req2, mem_read2, mem_write2, i_or_d2, ir_write2, pc_write2;
  logic [1:0]  pc_source2, alu_src_b2, alu_op2;
  logic        alu_src_a2, reg_dst2, reg_write2, mem_to_reg2, trap2;
  logic [3:0]  state2;
  logic [1:0]  retired2;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .state(state), .retired(retired), .trap(trap)
  );

  multicycle_control #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .opcode(opcode2), .zero(1'b0), .mem_ready(mem_ready2),
    .mem_req(mem_req2), .mem_read(mem_read2), .mem_write(mem_write2),
    .i_or_d(i_or_d2), .ir_write(ir_write2), .pc_write(pc_write2),
    .pc_source(pc_source2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2),
    .alu_op(alu_op2), .reg_dst(reg_dst2), .reg_write(reg_write2),
    .mem_to_reg(mem_to_reg2), .state(state2), .retired(retired2), .trap(trap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = 6'h23; mem_ready = 1'b1; zero = 1'b0;
    tick();
    tick();
    // Still in reset, state is FETCH and mem_ready=1: enables must stay low.
    checks++;
    if ({mem_req, mem_read, mem_write, ir_write, pc_write, reg_write} !== 6'b0) begin
      errors++;
      $display("FAIL reset_enables got %b want 000000",
               {mem_req, mem_read, mem_write, ir_write, pc_write, reg_write});
    end
    checks++;
    if ({pc_source, alu_src_b, alu_op} !== 6'b0) begin
      errors++;
      $display("FAIL reset_selects got %b want 000000", {pc_source, alu_src_b, alu_op});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || retired !== 16'd0 || trap !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got st=%0d ret=%0d trap=%b want 0 0 0", state, retired, trap);
    end
  endtask

  task automatic test_lw();
    logic [3:0] seq [5];
    seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    opcode = 6'h23; mem_ready = 1'b1;
    checks++;
    if ({mem_req, mem_read, ir_write, pc_write, alu_src_b} !== 6'b111101) begin
      errors++;
      $display("FAIL fetch_outputs got %b want 111101",
               {mem_req, mem_read, ir_write, pc_write, alu_src_b});
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (state !== seq[i]) begin
        errors++;
        $display("FAIL lw_state step %0d got %0d want %0d", i, state, seq[i]);
      end
      if (seq[i] == 4'd4) begin
        checks++;
        if ({mem_to_reg, reg_write, reg_dst} !== 3'b110) begin
          errors++;
          $display("FAIL lw_wb got %b want 110", {mem_to_reg, reg_write, reg_dst});
        end
      end
    end
    checks++;
    if (retired !== 16'd1) begin
      errors++;
      $display("FAIL lw_retired got %0d want 1", retired);
    end
  endtask

  task automatic test_sw_wait();
    opcode = 6'h2B; mem_ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (state !== 4'd5) begin
      errors++;
      $display("FAIL sw_enter got %0d want 5", state);
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      checks++;
      if (state !== 4'd5 || mem_write !== 1'b1 || i_or_d !== 1'b1 || retired !== 16'd1) begin
        errors++;
        $display("FAIL sw_hold cyc %0d got st=%0d mw=%b iord=%b ret=%0d want 5 1 1 1",
                 i, state, mem_write, i_or_d, retired);
      end
      tick();
    end
    checks++;
    if (state !== 4'd0 || retired !== 16'd2) begin
      errors++;
      $display("FAIL sw_done got st=%0d ret=%0d want 0 2", state, retired);
    end
  endtask

  task automatic test_beq();
    logic [1:0] zv;
    zv = 2'b01;
    opcode = 6'h04; mem_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      zero = zv[p];
      tick(); tick();
      checks++;
      if (state !== 4'd8 || pc_write !== zv[p] || pc_source !== 2'b01 || alu_op !== 2'b01) begin
        errors++;
        $display("FAIL beq_pass%0d got st=%0d pcw=%b pcs=%b aop=%b want 8 %b 01 01",
                 p, state, pc_write, pc_source, alu_op, zv[p]);
      end
      tick();
      checks++;
      if (state !== 4'd0) begin
        errors++;
        $display("FAIL beq_len%0d got %0d want 0", p, state);
      end
    end
    zero = 1'b0;
    checks++;
    if (retired !== 16'd4) begin
      errors++;
      $display("FAIL beq_retired got %0d want 4", retired);
    end
  endtask

  task automatic test_back_to_back();
    // R-type, ADDI, J: 4 + 4 + 3 = 11 cycles.
    opcode = 6'h00;
    tick(); tick(); tick();
    checks++;
    if (state !== 4'd7 || reg_dst !== 1'b1 || reg_write !== 1'b1) begin
      errors++;
      $display("FAIL rtype_wb got st=%0d rd=%b rw=%b want 7 1 1", state, reg_dst, reg_write);
    end
    tick();
    opcode = 6'h08;
    tick(); tick(); tick();
    checks++;
    if (state !== 4'd11 || reg_dst !== 1'b0 || reg_write !== 1'b1) begin
      errors++;
      $display("FAIL addi_wb got st=%0d rd=%b rw=%b want 11 0 1", state, reg_dst, reg_write);
    end
    tick();
    opcode = 6'h02;
    tick(); tick();
    checks++;
    if (state !== 4'd9 || pc_source !== 2'b10 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL jump got st=%0d pcs=%b pcw=%b want 9 10 1", state, pc_source, pc_write);
    end
    tick();
    checks++;
    if (state !== 4'd0 || retired !== 16'd7) begin
      errors++;
      $display("FAIL seq_retired got st=%0d ret=%0d want 0 7", state, retired);
    end
  endtask

  task automatic test_trap();
    opcode = 6'h3F; mem_ready = 1'b1; zero = 1'b1;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (state !== 4'd12 || trap !== 1'b1 || retired !== 16'd7 ||
          {mem_req, mem_read, mem_write, ir_write, pc_write, reg_write} !== 6'b0) begin
        errors++;
        $display("FAIL trap cyc %0d got st=%0d trap=%b ret=%0d en=%b want 12 1 7 0",
                 i, state, trap, retired,
                 {mem_req, mem_read, mem_write, ir_write, pc_write, reg_write});
      end
      tick();
    end
    zero = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || trap !== 1'b0 || retired !== 16'd0) begin
      errors++;
      $display("FAIL trap_clear got st=%0d trap=%b ret=%0d want 0 0 0", state, trap, retired);
    end
  endtask

  task automatic test_reset_mid_wait();
    opcode = 6'h23; mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    tick(); tick();
    checks++;
    if (state !== 4'd3 || mem_read !== 1'b1 || i_or_d !== 1'b1) begin
      errors++;
      $display("FAIL lw_wait got st=%0d mr=%b iord=%b want 3 1 1", state, mem_read, i_or_d);
    end
    mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_read, reg_write, ir_write, pc_write} !== 5'b0) begin
      errors++;
      $display("FAIL midwait_rst_en got %b want 00000",
               {mem_req, mem_read, reg_write, ir_write, pc_write});
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || retired !== 16'd0) begin
      errors++;
      $display("FAIL midwait_rst got st=%0d ret=%0d want 0 0", state, retired);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp [5];
    exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst2 = 1'b1; opcode2 = 6'h02; mem_ready2 = 1'b1;
    tick(); tick();
    rst2 = 1'b0;
    #1;
    checks++;
    if (retired2 !== 2'd0 || state2 !== 4'd0) begin
      errors++;
      $display("FAIL wrap_reset got st=%0d ret=%0d want 0 0", state2, retired2);
    end
    for (int i = 0; i < 5; i++) begin
      tick(); tick(); tick();
      checks++;
      if (retired2 !== exp[i] || state2 !== 4'd0) begin
        errors++;
        $display("FAIL wrap j%0d got st=%0d ret=%0d want 0 %0d", i, state2, retired2, exp[i]);
      end
    end
    mem_ready2 = 1'b0;
    tick();
    checks++;
    if (state2 !== 4'd0 || mem_req2 !== 1'b1 || ir_write2 !== 1'b0) begin
      errors++;
      $display("FAIL fetch_wait got st=%0d req=%b irw=%b want 0 1 0", state2, mem_req2, ir_write2);
    end
    rst2 = 1'b1;
    #1;
    checks++;
    if ({ir_write2, pc_write2, mem_req2} !== 3'b0) begin
      errors++;
      $display("FAIL fetch_rst_en got %b want 000", {ir_write2, pc_write2, mem_req2});
    end
    tick();
    checks++;
    if ({ir_write2, pc_write2} !== 2'b0 || state2 !== 4'd0 || retired2 !== 2'd0) begin
      errors++;
      $display("FAIL fetch_rst got en=%b st=%0d ret=%0d want 00 0 0",
               {ir_write2, pc_write2}, state2, retired2);
    end
    rst2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    opcode = 6'h00; opcode2 = 6'h00;
    zero = 1'b0; mem_ready = 1'b0; mem_ready2 = 1'b0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_back_to_back();
    test_trap();
    test_reset_mid_wait();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
